// File: rtl/stdout_uart_tx.sv
// Captures stdout strobe bytes into a FIFO and serialises them as UART frames on tx.
// Define STDOUT_UART_PARITY_EN to insert an even-parity bit between the data and the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low)
// DATA   | eight data bits, LSB first
// PARITY | even parity of the data byte (STDOUT_UART_PARITY_EN only)
// STOP   | stop bit (high); chains straight into the next START if a byte is queued
module stdout_uart_tx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int DEPTH_LOG2   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            stdout,
   input  logic                  stdout_en,
   output logic                  tx,
   output logic                  busy,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic                  overflow
);

   localparam int                DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [15:0]       BIT_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

`ifdef STDOUT_UART_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t                state;
   logic [15:0]           bit_timer;
   logic [2:0]            bit_idx;
   logic [7:0]            shift;
`ifdef STDOUT_UART_PARITY_EN
   logic                  parity;
`endif

   logic                  en_q;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;

   logic                  capture;
   logic                  bit_done;
   logic                  fifo_full;
   logic                  fifo_nonempty;
   logic                  pop;
   logic                  push;

   assign capture       = stdout_en & ~en_q;
   assign bit_done      = (bit_timer == BIT_LAST);
   assign fifo_full     = (fifo_count == FULL_CNT);
   assign fifo_nonempty = (fifo_count != '0);
   assign pop           = fifo_nonempty && ((state == IDLE) || ((state == STOP) && bit_done));
   // A full FIFO still accepts a byte when a slot is freed in the same cycle.
   assign push          = capture && (!fifo_full || pop);
   assign busy          = (state != IDLE) || fifo_nonempty;

   always_ff @(posedge clk) begin
      if (reset) begin
         en_q       <= 1'b1;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         en_q <= stdout_en;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            fifo_count <= fifo_count + 1'b1;
         else if (pop && !push)
            fifo_count <= fifo_count - 1'b1;
         if (capture && !push) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= stdout;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         tx        <= 1'b1;
         bit_timer <= '0;
         bit_idx   <= '0;
         shift     <= '0;
`ifdef STDOUT_UART_PARITY_EN
         parity    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               tx        <= 1'b1;
               bit_timer <= '0;
               if (pop) begin
                  shift  <= mem[rd_ptr];
`ifdef STDOUT_UART_PARITY_EN
                  parity <= ^mem[rd_ptr];
`endif
                  tx     <= 1'b0;
                  state  <= START;
               end
            end
            START: begin
               if (bit_done) begin
                  bit_timer <= '0;
                  bit_idx   <= '0;
                  tx        <= shift[0];
                  state     <= DATA;
               end else begin
                  bit_timer <= bit_timer + 16'd1;
               end
            end
            DATA: begin
               if (bit_done) begin
                  bit_timer <= '0;
                  if (bit_idx == 3'd7) begin
`ifdef STDOUT_UART_PARITY_EN
                     tx    <= parity;
                     state <= PARITY;
`else
                     tx    <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                  end
               end else begin
                  bit_timer <= bit_timer + 16'd1;
               end
            end
`ifdef STDOUT_UART_PARITY_EN
            PARITY: begin
               if (bit_done) begin
                  bit_timer <= '0;
                  tx        <= 1'b1;
                  state     <= STOP;
               end else begin
                  bit_timer <= bit_timer + 16'd1;
               end
            end
`endif
            STOP: begin
               if (bit_done) begin
                  bit_timer <= '0;
                  if (pop) begin
                     shift  <= mem[rd_ptr];
`ifdef STDOUT_UART_PARITY_EN
                     parity <= ^mem[rd_ptr];
`endif
                     tx     <= 1'b0;
                     state  <= START;
                  end else begin
                     tx    <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  bit_timer <= bit_timer + 16'd1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Bench for stdout_uart_tx: directed and random strobes checked against a queue-based timing model.
module tb_stdout_uart_tx;

   localparam int CPB   = 4;
   localparam int DL2   = 2;
   localparam int DEPTH = 1 << DL2;
`ifdef STDOUT_UART_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int F = NBITS * CPB;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [7:0]   stdout = 8'h00;
   logic         stdout_en = 1'b0;
   logic         tx;
   logic         busy;
   logic [DL2:0] fifo_count;
   logic         overflow;

   stdout_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
      .clk(clk), .reset(reset), .stdout(stdout), .stdout_en(stdout_en),
      .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   logic [7:0] rx_q[$];
   int         rx_t[$];
   logic [7:0] exp_q[$];
   int         exp_t[$];
   int         pop_q[$];
   int         last_pop = -1000000;
   bit         exp_ovf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Each accepted byte leaves the FIFO at max(capture+1, previous pop + frame time).
   task automatic model_capture(input logic [7:0] b, input int c, output int cnt);
      int occ = 0;
      bit popnow = 1'b0;
      int np;
      int keep[$];
      foreach (pop_q[i]) begin
         if (pop_q[i] >= c) begin
            occ++;
            keep.push_back(pop_q[i]);
         end
         if (pop_q[i] == c) popnow = 1'b1;
      end
      pop_q = keep;
      if (occ < DEPTH || popnow) begin
         np = (c + 1 > last_pop + F) ? c + 1 : last_pop + F;
         pop_q.push_back(np);
         last_pop = np;
         exp_q.push_back(b);
         exp_t.push_back(np);
      end else begin
         exp_ovf = 1'b1;
      end
      cnt = 0;
      foreach (pop_q[i]) if (pop_q[i] > c) cnt++;
   endtask

   task automatic model_reset();
      pop_q.delete();
      exp_q.delete();
      exp_t.delete();
      last_pop = -1000000;
      exp_ovf = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      int cnt;
      stdout = b;
      stdout_en = 1'b1;
      tick();
      model_capture(b, cyc, cnt);
      chk("count_after_capture", 32'(fifo_count), cnt);
      stdout_en = 1'b0;
      repeat (gap - 1) tick();
   endtask

   task automatic finish_test(input string name);
      int n;
      while (cyc < last_pop + F - 1) tick();
      if (cyc == last_pop + F - 1) chk({name, "_busy_last_stop"}, 32'(busy), 1);
      tick();
      chk({name, "_busy_done"}, 32'(busy), 0);
      chk({name, "_tx_idle"}, 32'(tx), 1);
      chk({name, "_count_empty"}, 32'(fifo_count), 0);
      chk({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
      repeat (3) tick();
      chk({name, "_frames"}, rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk({name, "_rx_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
         chk({name, "_rx_start_cycle"}, rx_t[i], exp_t[i]);
      end
      rx_q.delete();
      rx_t.delete();
      exp_q.delete();
      exp_t.delete();
   endtask

   // Line decoder: samples each bit mid-way; a frame cut short by reset is discarded.
   initial begin : monitor
      logic [NBITS-1:0] bits;
      int t0;
      bit ab;
      forever begin
         @(negedge clk);
         if (reset !== 1'b0 || tx !== 1'b0) continue;
         t0 = cyc;
         ab = 1'b0;
         bits = '0;
         for (int s = 0; s < NBITS * CPB; s++) begin
            if (s > 0) @(negedge clk);
            if (reset) begin
               ab = 1'b1;
               break;
            end
            if (s % CPB == CPB / 2) bits[s / CPB] = tx;
         end
         if (!ab) begin
            chk("start_bit", 32'(bits[0]), 0);
            chk("stop_bit", 32'(bits[NBITS-1]), 1);
`ifdef STDOUT_UART_PARITY_EN
            chk("parity_bit", 32'(bits[9]), 32'(^bits[8:1]));
`endif
            rx_q.push_back(bits[8:1]);
            rx_t.push_back(t0);
         end
      end
   end

   initial begin : stimulus
      int cnt;
      int peak;
      reset = 1'b1;
      stdout_en = 1'b1;
      repeat (3) tick();
      chk("reset_tx", 32'(tx), 1);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_count", 32'(fifo_count), 0);
      chk("reset_overflow", 32'(overflow), 0);
      reset = 1'b0;
      repeat (5) tick();
      chk("strobe_through_reset_count", 32'(fifo_count), 0);
      chk("strobe_through_reset_busy", 32'(busy), 0);
      stdout_en = 1'b0;
      repeat (2) tick();
      model_reset();

      // single byte, strobe held for 2 cycles
      stdout = 8'h41;
      stdout_en = 1'b1;
      tick();
      model_capture(8'h41, cyc, cnt);
      chk("single_tx_high_at_capture", 32'(tx), 1);
      chk("single_count_at_capture", 32'(fifo_count), cnt);
      tick();
      chk("single_tx_start", 32'(tx), 0);
      chk("single_count_popped", 32'(fifo_count), 0);
      chk("single_busy", 32'(busy), 1);
      stdout_en = 1'b0;
      finish_test("single");

      send(8'h07, 2);
      finish_test("single07");

      // held strobe
      stdout = 8'h55;
      stdout_en = 1'b1;
      tick();
      model_capture(8'h55, cyc, cnt);
      chk("held_count", 32'(fifo_count), cnt);
      peak = fifo_count;
      repeat (49) begin
         tick();
         if (fifo_count > peak) peak = fifo_count;
      end
      chk("held_peak", peak, 1);
      stdout_en = 1'b0;
      finish_test("held");

      // back-to-back
      send(8'h00, 2);
      send(8'hFF, 2);
      finish_test("b2b");

      // random bursts
      for (int i = 0; i < 25; i++) send(8'($urandom), $urandom_range(2, 30));
      finish_test("random");

      // overflow
      for (int i = 0; i < 6; i++) send(8'h30 + 8'(i), 2);
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_model_flag", 32'(exp_ovf), 1);
      finish_test("overflow");

      // reset during data bit 3 with two bytes still queued
      send(8'hA1, 3);
      send(8'hB2, 3);
      send(8'hC3, 3);
      while (cyc < exp_t[0] + 4 * CPB + 1) tick();
      chk("rst_mid_queued", 32'(fifo_count), 2);
      chk("rst_mid_tx_low_bit3", 32'(tx), 0);
      reset = 1'b1;
      tick();
      chk("rst_mid_tx", 32'(tx), 1);
      chk("rst_mid_count", 32'(fifo_count), 0);
      chk("rst_mid_overflow", 32'(overflow), 0);
      chk("rst_mid_busy", 32'(busy), 0);
      reset = 1'b0;
      model_reset();
      rx_q.delete();
      rx_t.delete();
      repeat (12 * CPB) tick();
      chk("rst_mid_no_frames", rx_q.size(), 0);
      chk("rst_mid_tx_idle", 32'(tx), 1);
      chk("rst_mid_busy_idle", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
